// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator on the 25 MHz pixel clock.
// Fetch coordinates come straight from the counters. Enables, syncs and
// start pulses are registered one cycle later, so colour looked up from
// pix_x/pix_y and registered once lines up with hen/ven.
module vga_timing_gen #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0
) (
    input  logic       clk25m,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       hen,
    output logic       ven,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_VIS + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_VIS + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [31:0]      hcnt_w, vcnt_w;
    logic             h_wrap;

    logic hen_q, hen_d;
    logic ven_q, ven_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Counters widened to 32 bits so all compares against the parameters match in width
    assign hcnt_w = 32'(hcnt_q);
    assign vcnt_w = 32'(vcnt_q);

    // Next counter values; anything at or beyond the last legal value wraps to 0
    always_comb begin
        h_wrap = (hcnt_w >= (H_TOTAL - 32'd1));
        hcnt_d = h_wrap ? '0 : hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (vcnt_w >= V_TOTAL) begin
            vcnt_d = '0;
        end else if (h_wrap) begin
            vcnt_d = (vcnt_w >= (V_TOTAL - 32'd1)) ? '0 : vcnt_q + CNT_W'(1);
        end
    end

    // Registered outputs decoded from the pre-increment counter values
    always_comb begin
        hen_d         = (hcnt_w < H_VIS);
        ven_d         = (vcnt_w < V_VIS);
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        line_start_d  = (hcnt_q == '0);
        frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
        if ((hcnt_w >= HS_BEG) && (hcnt_w < HS_END)) begin
            hsync_d = HS_POL;
        end
        if ((vcnt_w >= VS_BEG) && (vcnt_w < VS_END)) begin
            vsync_d = VS_POL;
        end
    end

    // State and output registers; reset drops any sync pulse in progress
    always_ff @(posedge clk25m) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hen_q         <= 1'b0;
            ven_q         <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hen_q         <= hen_d;
            ven_q         <= ven_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Fetch coordinates are held at zero while reset is asserted
    assign pix_x     = reset ? '0 : hcnt_q;
    assign pix_y     = reset ? '0 : vcnt_q;
    assign pix_valid = ~reset && (hcnt_w < H_VIS) && (vcnt_w < V_VIS);

    assign hen         = hen_q;
    assign ven         = ven_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA path, clocked from the 25 MHz pixel clock. Produces the horizontal/vertical sync pulses, the `hen`/`ven` display-enable strobes consumed by the colour gating/output stage, and pixel fetch coordinates issued one cycle ahead of the enables. The colour output stage registers incoming colour by one cycle, so colour looked up combinationally from `pix_x`/`pix_y` arrives aligned with `hen`/`ven`.

## Interface
Parameters:
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level (0 = active-low)

Ports:
- `clk25m`  in  1  pixel clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `hsync`  out  1  horizontal sync, registered
- `vsync`  out  1  vertical sync, registered
- `hen`  out  1  horizontal display enable, registered
- `ven`  out  1  vertical display enable, registered
- `pix_x`  out  10  fetch column (current horizontal counter)
- `pix_y`  out  10  fetch row (current vertical counter)
- `pix_valid`  out  1  fetch coordinate is inside visible area
- `line_start`  out  1  one-cycle pulse, aligned with first `hen` cycle of each line (including blank lines)
- `frame_start`  out  1  one-cycle pulse, aligned with first `hen`&`ven` cycle of a frame

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024; counters are 10 bits.
- `hcnt` counts 0..H_TOTAL-1, wraps to 0. `vcnt` increments only when `hcnt` wraps; counts 0..V_TOTAL-1, wraps to 0. No other wrap values are legal; any value ≥ TOTAL returns to 0 on the next clock.
- `pix_x` = `hcnt`, `pix_y` = `vcnt`; `pix_valid` = (`hcnt` < H_VIS) & (`vcnt` < V_VIS). All three forced to 0 while `reset` is high.
- Registered each clock from the pre-increment counter values:
  - `hen` <= `hcnt` < H_VIS; `ven` <= `vcnt` < V_VIS.
  - `hsync` <= HS_POL when H_VIS+H_FP ≤ `hcnt` < H_VIS+H_FP+H_SYNC, else ~HS_POL.
  - `vsync` <= VS_POL when V_VIS+V_FP ≤ `vcnt` < V_VIS+V_FP+V_SYNC, else ~VS_POL (changes only at line boundaries).
  - `line_start` <= `hcnt`==0; `frame_start` <= (`hcnt`==0)&(`vcnt`==0).
- Reset values: `hcnt`=`vcnt`=0, `hen`=`ven`=0, `hsync`=~HS_POL, `vsync`=~VS_POL, `line_start`=`frame_start`=0.
- Reset asserted mid-frame: all state returns to reset values on the next edge; no partial sync pulse is held.

## Timing
- Cycle 0 = first cycle with `reset` low; `hcnt`=`vcnt`=0 in cycle 0, `pix_valid`=1.
- Fixed latency: registered outputs lag `pix_x`/`pix_y` by exactly 1 cycle.
- Cycle 1: `hen`=`ven`=1, `line_start`=`frame_start`=1. Cycle 2: both pulses 0.
- `hen` low from cycle 641 to 800 inclusive; high again at cycle 801 (line 1, `line_start`=1).
- `hsync` active cycles 657..752 of each line (96 clocks), relative to line start at cycle 1.
- `pix_y`=480 from cycle 384000; `ven` falls at cycle 384001.
- `vsync` active from cycle 392001 for 1600 cycles (2 lines).
- Frame period 420000 cycles; second `frame_start` at cycle 420001.

## Test plan
- Reset release: hold `reset` 5 cycles, release -> during reset `hsync`=`vsync`=1, `hen`=`ven`=`pix_valid`=0; cycle 0 `pix_valid`=1; cycle 1 `frame_start`=`hen`=`ven`=1.
- Line timing: run 2 lines -> `hen` high 640 clocks, `hsync` low exactly cycles 657..752 and 1457..1552; `line_start` at cycles 1 and 801.
- Frame timing: run 2 frames -> `ven` high 384000 clocks, `vsync` low 1600 clocks starting 392001, `frame_start` only at 1 and 420001; `pix_y` wraps 524->0 at cycle 420000.
- Alignment: model colour = f(`pix_x`,`pix_y`) registered 1 cycle -> every cycle with `hen`&`ven` carries colour for coordinates inside 0..639 x 0..479, each exactly once per frame.
- Mid-frame reset: assert `reset` at cycle 200123 for 1 cycle -> next cycle all outputs at reset values; after release timing restarts exactly as in scenario 1.
- Parameter override: H_VIS=8,H_FP=2,H_SYNC=3,H_BP=3,V_VIS=4,V_FP=1,V_SYNC=1,V_BP=1 -> line 16 clocks, frame 112 clocks, `hsync` low cycles 11..13 of each line.
